// File: rtl/sdc_pkg.sv
// Shared types and constants for the loadable synchronous down counter.
package sdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sdc_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tff_load_cell.sv
// One bit of the down counter: a T flip-flop with a parallel load input.
// Synchronous active-low reset to 0; a load overrides the toggle request.
module tff_load_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic r_q;

    // Reset first, then load, then toggle; otherwise hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else if (ld) begin
            r_q <= d;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter built from a chain of T flip-flop cells.
// Counts from the loaded value to zero, flags terminal count, then either stops
// (one-shot) or reloads the stored start value (periodic).
// Optional feature macro: SDC_TC_COUNT_EN adds an 8-bit saturating count of tc events.
module sync_down_counter
    import sdc_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
`ifdef SDC_TC_COUNT_EN
    ,
    output logic [7:0]       tc_count
`endif
);

    sdc_state_t       r_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_lowZero;
    logic [WIDTH-1:0] w_d;
    logic             w_enRun;
    logic             w_qNonZero;
    logic             w_tc;
    logic             w_ld;

    // Counting only happens while running and enabled; at zero the count
    // stops borrowing and terminal count is raised instead.
    assign w_enRun    = (r_state == RUN) & en;
    assign w_qNonZero = |w_q;
    assign w_tc       = w_enRun & ~w_qNonZero;

    // A periodic terminal count reuses the cells' load path to restore the
    // reload value; an external load always takes priority over that.
    assign w_ld = load | (w_tc & (mode == MODE_PERIODIC));
    assign w_d  = load ? load_val : r_reload;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gCell
            // Bit i toggles only when every lower bit is zero (borrow chain)
            if (gi == 0) begin : gLsb
                assign w_lowZero[gi] = 1'b1;
            end else begin : gUpper
                assign w_lowZero[gi] = w_lowZero[gi-1] & ~w_q[gi-1];
            end

            assign w_toggle[gi] = w_enRun & w_qNonZero & w_lowZero[gi];

            tff_load_cell uCell (
                .clk (clk),
                .rst (rst),
                .t   (w_toggle[gi]),
                .ld  (w_ld),
                .d   (w_d[gi]),
                .q   (w_q[gi])
            );
        end
    endgenerate

    // State: load starts a run from any state; a one-shot terminal count parks in DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (load) begin
            r_state <= RUN;
        end else if (w_tc && (mode == MODE_ONESHOT)) begin
            r_state <= DONE;
        end
    end

    // Reload register remembers the last loaded start value for periodic mode
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reload <= '0;
        end else if (load) begin
            r_reload <= load_val;
        end
    end

    // Done is a one-cycle pulse after a terminal count that was not overridden by a load
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_tc & ~load;
        end
    end

`ifdef SDC_TC_COUNT_EN
    logic [7:0] r_tcCount;

    // Saturating count of terminal-count events, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tcCount <= 8'd0;
        end else if (w_tc && (r_tcCount != 8'hFF)) begin
            r_tcCount <= r_tcCount + 8'd1;
        end
    end

    assign tc_count = r_tcCount;
`endif

    assign q    = w_q;
    assign tc   = w_tc;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule
